// File: rtl/display_scanner_pkg.sv
// Shared constants for the seven-segment scanner: segment table, blank code
// and the counter-width helper.
package display_pkg;

  typedef logic [7:0] cat_t;

  localparam cat_t BLANK_CAT = 8'hFF;

  // Index 0 is the rightmost entry; codes are g..a, active low.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Never returns less than 1 so a single-value counter still gets a real bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Display register side (value, dot, enable, blanking, brightness) and the
// board-pin side (AN, CAT) of the scanner, plus the frame strobe.
interface display_scanner_if #(parameter int DIGITS = 8);

  logic [4*DIGITS-1:0] DATA;
  logic [DIGITS-1:0]   DOT;
  logic [DIGITS-1:0]   ENA;
  logic                LZB;
  logic [3:0]          BRIGHT;
  logic [DIGITS-1:0]   AN;
  logic [7:0]          CAT;
  logic                FRAME;

  modport master (output DATA, DOT, ENA, LZB, BRIGHT, input AN, CAT, FRAME);
  modport slave  (input DATA, DOT, ENA, LZB, BRIGHT, output AN, CAT, FRAME);

endinterface

// File: rtl/display_scanner_seg7_decode.sv
// Hex value plus decimal point to active-low cathode pattern.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dot,
  output cat_t       cat
);

  assign cat = {~dot, SEG_TABLE[val]};

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input
// snapshot, leading-zero blanking and 16-step brightness PWM.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 16384
) (
  input  logic              CLK,
  input  logic              RES,
  display_scanner_if.slave  bus
);

  localparam int SUB_N = SCAN_DIV / 16;
  localparam int SUB_W = clog2(SUB_N);
  localparam int DIG_W = clog2(DIGITS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_N - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [3:0]          ph_q, ph_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dot_q, dot_d;
  logic [DIGITS-1:0]   ena_q, ena_d;
  logic                lzb_q, lzb_d;
  logic [3:0]          bright_q, bright_d;
  logic [DIGITS-1:0]   an_q, an_d;
  cat_t                cat_q, cat_d;
  logic                frame_q, frame_d;

  logic              frame_start;
  logic [DIGITS-1:0] blank;
  logic [3:0]        cur_val;
  logic              cur_dot;
  logic              cur_ena;
  logic              cur_blank;
  logic              lit;
  cat_t              seg_cat;

  always_comb begin
    frame_start = (sub_q == '0) && (ph_q == '0) && (dig_q == '0);
    sub_d = sub_q + 1'b1;
    ph_d  = ph_q;
    dig_d = dig_q;
    if (sub_q == SUB_LAST) begin
      sub_d = '0;
      ph_d  = ph_q + 4'd1;
      if (ph_q == 4'hF) begin
        dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end
    end
  end

  // The output for the first slot of a frame is built from the values being
  // captured on that same edge, so the whole frame uses one snapshot.
  always_comb begin
    data_d   = frame_start ? bus.DATA   : data_q;
    dot_d    = frame_start ? bus.DOT    : dot_q;
    ena_d    = frame_start ? bus.ENA    : ena_q;
    lzb_d    = frame_start ? bus.LZB    : lzb_q;
    bright_d = frame_start ? bus.BRIGHT : bright_q;
  end

  always_comb begin
    logic run;
    blank = '0;
    run   = lzb_d;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run      = run && (data_d[4*i +: 4] == 4'h0) && !dot_d[i];
      blank[i] = run && (i != 0);
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_dot   = 1'b0;
    cur_ena   = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (DIG_W'(i) == dig_q) begin
        cur_val   = data_d[4*i +: 4];
        cur_dot   = dot_d[i];
        cur_ena   = ena_d[i];
        cur_blank = blank[i];
      end
    end
  end

  seg7_decode u_dec (
    .val (cur_val),
    .dot (cur_dot),
    .cat (seg_cat)
  );

  always_comb begin
    lit     = cur_ena && !cur_blank && (ph_q <= bright_d);
    an_d    = '1;
    cat_d   = BLANK_CAT;
    frame_d = frame_start;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << dig_q);
      cat_d = seg_cat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      sub_q    <= '0;
      ph_q     <= '0;
      dig_q    <= '0;
      data_q   <= '0;
      dot_q    <= '0;
      ena_q    <= '0;
      lzb_q    <= 1'b0;
      bright_q <= '0;
      an_q     <= '1;
      cat_q    <= BLANK_CAT;
      frame_q  <= 1'b0;
    end else begin
      sub_q    <= sub_d;
      ph_q     <= ph_d;
      dig_q    <= dig_d;
      data_q   <= data_d;
      dot_q    <= dot_d;
      ena_q    <= ena_d;
      lzb_q    <= lzb_d;
      bright_q <= bright_d;
      an_q     <= an_d;
      cat_q    <= cat_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.AN    = an_q;
  assign bus.CAT   = cat_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner with a cycle-count reference model
// and hand-computed spot checks.
module tb_display_scanner;

  localparam int ND   = 4;
  localparam int SD   = 16;
  localparam int FL   = ND * SD;
  localparam int SUBN = SD / 16;

  logic clk;
  logic res;

  display_scanner_if #(.DIGITS(ND)) bus ();

  display_scanner #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference: position in the frame is just the count of running cycles.
  int         mk;
  logic [15:0] s_data;
  logic [3:0]  s_dot, s_ena, s_bright;
  logic        s_lzb;
  logic [3:0]  e_an;
  logic [7:0]  e_cat;
  logic        e_frame;
  bit          mvalid = 0;

  always @(posedge clk) begin
    int pos, d, ph;
    bit blk, lit;
    logic [3:0] v;
    if (res) begin
      mk = 0;
      e_an = 4'hF; e_cat = 8'hFF; e_frame = 1'b0;
    end else begin
      pos = mk % FL;
      if (pos == 0) begin
        s_data = bus.DATA; s_dot = bus.DOT; s_ena = bus.ENA;
        s_lzb = bus.LZB; s_bright = bus.BRIGHT;
      end
      d  = pos / SD;
      ph = (pos % SD) / SUBN;
      v  = s_data[4*d +: 4];
      blk = s_lzb && (d != 0);
      for (int j = d; j < ND; j++)
        if (s_data[4*j +: 4] != 4'h0 || s_dot[j]) blk = 0;
      lit = s_ena[d] && !blk && (ph <= int'(s_bright));
      if (lit) begin
        e_an  = ~(4'b0001 << d);
        e_cat = {~s_dot[d], seg_ref[v]};
      end else begin
        e_an = 4'hF; e_cat = 8'hFF;
      end
      e_frame = (pos == 0);
      mk++;
    end
    mvalid = 1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      vectors++;
      if (bus.AN !== e_an || bus.CAT !== e_cat || bus.FRAME !== e_frame) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t AN got %h exp %h CAT got %h exp %h FRAME got %b exp %b",
                 $time, bus.AN, e_an, bus.CAT, e_cat, bus.FRAME, e_frame);
      end
    end
  end

  int fcount = 0;
  always @(negedge clk) if (bus.FRAME === 1'b1) fcount++;

  int sk;

  task automatic step();
    @(negedge clk);
    sk++;
  endtask

  task automatic goto(input int t);
    while (sk < t) step();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] an, input logic [7:0] cat);
    chk({name, "_an"}, 32'(bus.AN), 32'(an));
    chk({name, "_cat"}, 32'(bus.CAT), 32'(cat));
  endtask

  int f0;

  initial begin
    res = 1'b1;
    sk  = 0;
    bus.DATA = 16'h1234; bus.DOT = 4'h0; bus.ENA = 4'hF;
    bus.LZB = 1'b0; bus.BRIGHT = 4'hF;

    repeat (5) begin
      @(negedge clk);
      chk_out("reset", 4'hF, 8'hFF);
      chk("reset_frame", 32'(bus.FRAME), 32'd0);
    end
    res = 1'b0; sk = -1;

    goto(0);  chk("first_frame", 32'(bus.FRAME), 32'd1); chk_out("d0_k0", 4'hE, 8'h99);
    goto(8);  chk_out("d0", 4'hE, 8'h99);
    goto(10); f0 = fcount;
    goto(24); chk_out("d1", 4'hD, 8'hB0);
    goto(40); chk_out("d2", 4'hB, 8'hA4);
    goto(56); chk_out("d3", 4'h7, 8'hF9);

    goto(60); bus.DATA = 16'h0050; bus.LZB = 1'b1;
    goto(72);  chk_out("lzb_d0", 4'hE, 8'hC0);
    goto(88);  chk_out("lzb_d1", 4'hD, 8'h92);
    goto(100); bus.DOT = 4'b1000;
    goto(104); chk_out("lzb_d2", 4'hF, 8'hFF);
    goto(120); chk_out("lzb_d3", 4'hF, 8'hFF);
    goto(136); chk_out("dot_d0", 4'hE, 8'hC0);
    goto(168); chk_out("dot_d2", 4'hB, 8'hC0);
    goto(184); chk_out("dot_d3", 4'h7, 8'h40);

    goto(186); bus.DATA = 16'h1234; bus.DOT = 4'h0; bus.LZB = 1'b0; bus.BRIGHT = 4'd3;
    goto(192); chk_out("pwm_ph0", 4'hE, 8'h99);
    goto(195); chk_out("pwm_ph3", 4'hE, 8'h99);
    goto(196); chk_out("pwm_ph4", 4'hF, 8'hFF);

    goto(250); bus.DATA = 16'h1111; bus.BRIGHT = 4'hF;
    goto(266); chk("frame_count", 32'(fcount - f0), 32'd4);
    goto(286); bus.DATA = 16'h2222;
    goto(296); chk_out("coh_old", 4'hB, 8'hF9);
    goto(336); chk_out("coh_new", 4'hD, 8'hA4);

    goto(350); bus.ENA = 4'b1010;
    goto(392); chk_out("ena_d0", 4'hF, 8'hFF);
    goto(408); chk_out("ena_d1", 4'hD, 8'hA4);

    goto(434); res = 1'b1;
    step();
    chk_out("midreset", 4'hF, 8'hFF);
    chk("midreset_frame", 32'(bus.FRAME), 32'd0);
    res = 1'b0; sk = -1;
    goto(0);  chk("restart_frame", 32'(bus.FRAME), 32'd1); chk_out("restart_d0", 4'hF, 8'hFF);
    goto(16); chk_out("restart_d1", 4'hD, 8'hA4);

    for (int i = 0; i < 40; i++) begin
      int n;
      n = $urandom_range(1, 120);
      repeat (n) step();
      if ($urandom_range(0, 9) == 0) begin
        res = 1'b1;
        step();
        res = 1'b0; sk = -1;
      end else begin
        bus.DATA = 16'($urandom);
        if ($urandom_range(0, 1) == 1)
          bus.DATA = bus.DATA & (16'hFFFF >> (4 * $urandom_range(1, 4)));
        bus.DOT    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        bus.ENA    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        bus.LZB    = 1'($urandom);
        bus.BRIGHT = 4'($urandom);
      end
    end
    repeat (FL) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
